// File: rtl/instr_fetch_unit.sv
// Fetch-stage controller: one outstanding imem request at a time, a small
// instruction FIFO toward decode, and redirect handling that flushes/squashes.
module instr_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   CountFull = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CountOne  = (AW + 1)'(1);
    localparam logic [AW-1:0] PtrOne    = AW'(1);

    typedef enum logic {
        ST_FETCH,
        ST_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic          drop_q, drop_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic accept;
    logic resp;
    logic push;
    logic pop;

    assign imem_req  = !reset && (state_q == ST_FETCH) && (count_q < CountFull) && !redirect_valid;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;
    assign resp      = (state_q == ST_WAIT) && imem_rvalid;
    assign push      = resp && !drop_q && !redirect_valid;
    assign id_valid  = (count_q != '0);
    assign pop       = id_valid && id_ready && !redirect_valid;
    assign id_instr  = instr_mem_q[rd_ptr_q];
    assign id_pc     = pc_mem_q[rd_ptr_q];

    // PC register control: reset value, then redirect, then sequential fetch.
    always_comb begin
        pc_en   = 1'b0;
        next_pc = pc;
        if (reset) begin
            next_pc = RESET_PC;
        end else if (redirect_valid) begin
            pc_en   = 1'b1;
            next_pc = {redirect_pc[31:2], 2'b00};
        end else if (accept) begin
            pc_en   = 1'b1;
            next_pc = pc + 32'd4;
        end
    end

    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        req_pc_d = req_pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            // A response landing with the redirect consumes the squash itself.
            if (state_q == ST_WAIT) begin
                if (imem_rvalid) begin
                    state_d = ST_FETCH;
                    drop_d  = 1'b0;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end else begin
            if (accept) begin
                state_d  = ST_WAIT;
                req_pc_d = pc;
            end
            if (resp) begin
                state_d = ST_FETCH;
                drop_d  = 1'b0;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            if (push && !pop) begin
                count_d = count_q + CountOne;
            end else if (pop && !push) begin
                count_d = count_q - CountOne;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            drop_q   <= 1'b0;
            req_pc_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            req_pc_q <= req_pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clock) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC register model and a simple
// instruction memory whose response latency is programmable per grant.
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] pcReg;
    logic [31:0] next_pc;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int          checks;
    int          errors;
    int          rvalidDelay;
    int          pendCnt;
    logic        pendValid;
    logic [31:0] pendAddr;

    instr_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pcReg),
        .next_pc        (next_pc),
        .pc_en          (pc_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clock = ~clock;

    // PC register fed by the DUT's next_pc/pc_en.
    always @(posedge clock or posedge reset) begin
        if (reset) pcReg <= 32'h0000_0000;
        else if (pc_en) pcReg <= next_pc;
    end

    // Memory returns {16'hC0DE, addr[15:0]} rvalidDelay cycles after the cycle following the grant.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
            pendValid   <= 1'b0;
            pendAddr    <= '0;
            pendCnt     <= 0;
        end else begin
            imem_rvalid <= 1'b0;
            if (imem_req && imem_gnt) begin
                if (rvalidDelay == 0) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= {16'hC0DE, imem_addr[15:0]};
                end else begin
                    pendValid <= 1'b1;
                    pendAddr  <= imem_addr;
                    pendCnt   <= rvalidDelay - 1;
                end
            end else if (pendValid) begin
                if (pendCnt == 0) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= {16'hC0DE, pendAddr[15:0]};
                    pendValid   <= 1'b0;
                end else begin
                    pendCnt <= pendCnt - 1;
                end
            end
        end
    end

    task automatic doReset();
        reset          = 1'b1;
        imem_gnt       = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rvalidDelay    = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        imem_gnt       = 1'b1;
        id_ready       = 1'b1;
        rvalidDelay    = 0;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req actual=%0b required=0", imem_req); end
        checks++; if (pc_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_pc_en actual=%0b required=0", pc_en); end
        checks++; if (next_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_next_pc actual=%h required=00000000", next_pc); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_valid actual=%0b required=0", id_valid); end
        redirect_valid = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        logic [31:0] p;
        doReset();
        id_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            e = 32'(4 * k);
            checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL seq_req k=%0d actual=%0b required=1", k, imem_req); end
            checks++; if (imem_addr !== e) begin errors++; $display("[TB] FAIL seq_addr actual=%h required=%h", imem_addr, e); end
            checks++; if (pc_en !== 1'b1) begin errors++; $display("[TB] FAIL seq_pc_en k=%0d actual=%0b required=1", k, pc_en); end
            checks++; if (next_pc !== e + 32'd4) begin errors++; $display("[TB] FAIL seq_next_pc actual=%h required=%h", next_pc, e + 32'd4); end
            if (k > 0) begin
                p = e - 32'd4;
                checks++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_id_valid k=%0d actual=%0b required=1", k, id_valid); end
                checks++; if (id_pc !== p) begin errors++; $display("[TB] FAIL seq_id_pc actual=%h required=%h", id_pc, p); end
                checks++; if (id_instr !== {16'hC0DE, p[15:0]}) begin errors++; $display("[TB] FAIL seq_id_instr actual=%h required=%h", id_instr, {16'hC0DE, p[15:0]}); end
            end
            @(negedge clock); #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL seq_wait_req k=%0d actual=%0b required=0", k, imem_req); end
            checks++; if (pc_en !== 1'b0) begin errors++; $display("[TB] FAIL seq_wait_pc_en k=%0d actual=%0b required=0", k, pc_en); end
            @(negedge clock); #1;
        end
        checks++; if (id_pc !== 32'h8) begin errors++; $display("[TB] FAIL seq_last_id_pc actual=%h required=00000008", id_pc); end
        checks++; if (id_instr !== 32'hC0DE_0008) begin errors++; $display("[TB] FAIL seq_last_instr actual=%h required=c0de0008", id_instr); end
    endtask

    task automatic test_backpressure();
        doReset();
        #1;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL bp_addr0 actual=%h required=00000000", imem_addr); end
        repeat (2) @(negedge clock); #1;
        checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL bp_req4 addr=%h req=%0b required addr=4 req=1", imem_addr, imem_req); end
        repeat (2) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_req i=%0d actual=%0b required=0", i, imem_req); end
            checks++; if (pc_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_pc_en i=%0d actual=%0b required=0", i, pc_en); end
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++; $display("[TB] FAIL bp_head i=%0d valid=%0b pc=%h required valid=1 pc=0", i, id_valid, id_pc); end
            @(negedge clock);
        end
        id_ready = 1'b1;
        #1;
        checks++; if (id_instr !== 32'hC0DE_0000) begin errors++; $display("[TB] FAIL bp_pop0_instr actual=%h required=c0de0000", id_instr); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_pop0_req actual=%0b required=0", imem_req); end
        @(negedge clock); #1;
        checks++; if (id_pc !== 32'h4 || id_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_pop4 pc=%h valid=%0b required pc=4 valid=1", id_pc, id_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL bp_resume req=%0b addr=%h required req=1 addr=8", imem_req, imem_addr); end
        @(negedge clock); #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained actual=%0b required=0", id_valid); end
        @(negedge clock); #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8) begin errors++; $display("[TB] FAIL bp_head8 valid=%0b pc=%h required valid=1 pc=8", id_valid, id_pc); end
        id_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        doReset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_000C;
        #1;
        checks++; if (pc_en !== 1'b1 || next_pc !== 32'hC || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rw_init pc_en=%0b next_pc=%h req=%0b required 1/0000000c/0", pc_en, next_pc, imem_req); end
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("[TB] FAIL rw_reqC req=%0b addr=%h required req=1 addr=c", imem_req, imem_addr); end
        repeat (2) @(negedge clock);
        rvalidDelay = 3;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL rw_req10 req=%0b addr=%h required req=1 addr=10", imem_req, imem_addr); end
        @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        checks++; if (next_pc !== 32'h100) begin errors++; $display("[TB] FAIL rw_next_pc actual=%h required=00000100", next_pc); end
        checks++; if (pc_en !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rw_pc_en pc_en=%0b req=%0b required 1/0", pc_en, imem_req); end
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hC) begin errors++; $display("[TB] FAIL rw_pre_flush valid=%0b pc=%h required valid=1 pc=c", id_valid, id_pc); end
        @(negedge clock);
        redirect_valid = 1'b0;
        rvalidDelay    = 0;
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rw_flushed actual=%0b required=0", id_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rw_still_wait actual=%0b required=0", imem_req); end
        repeat (2) @(negedge clock); #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rw_drop_cycle_req actual=%0b required=0", imem_req); end
        @(negedge clock); #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rw_squashed actual=%0b required=0", id_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL rw_req100 req=%0b addr=%h required req=1 addr=100", imem_req, imem_addr); end
        repeat (2) @(negedge clock); #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin errors++; $display("[TB] FAIL rw_head100 valid=%0b pc=%h required valid=1 pc=100", id_valid, id_pc); end
        checks++; if (id_instr !== 32'hC0DE_0100) begin errors++; $display("[TB] FAIL rw_instr100 actual=%h required=c0de0100", id_instr); end
    endtask

    task automatic test_redirect_rvalid_pop();
        doReset();
        repeat (3) @(negedge clock);
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++; $display("[TB] FAIL rrp_head valid=%0b pc=%h required valid=1 pc=0", id_valid, id_pc); end
        checks++; if (next_pc !== 32'h40 || pc_en !== 1'b1) begin errors++; $display("[TB] FAIL rrp_redirect next_pc=%h pc_en=%0b required 00000040/1", next_pc, pc_en); end
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rrp_flushed actual=%0b required=0", id_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL rrp_fetch req=%0b addr=%h required req=1 addr=40", imem_req, imem_addr); end
        repeat (2) @(negedge clock); #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin errors++; $display("[TB] FAIL rrp_head40 valid=%0b pc=%h required valid=1 pc=40", id_valid, id_pc); end
        id_ready = 1'b0;
    endtask

    task automatic test_gnt_stall();
        doReset();
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL gs_hold i=%0d req=%0b addr=%h required req=1 addr=0", i, imem_req, imem_addr); end
            checks++; if (pc_en !== 1'b0 || next_pc !== 32'h0) begin errors++; $display("[TB] FAIL gs_no_pc_en i=%0d pc_en=%0b next_pc=%h required 0/00000000", i, pc_en, next_pc); end
            @(negedge clock);
        end
        imem_gnt = 1'b1;
        #1;
        checks++; if (pc_en !== 1'b1 || next_pc !== 32'h4) begin errors++; $display("[TB] FAIL gs_accept pc_en=%0b next_pc=%h required 1/00000004", pc_en, next_pc); end
        @(negedge clock);
        imem_gnt = 1'b0;
        #1;
        checks++; if (pc_en !== 1'b0 || pcReg !== 32'h4) begin errors++; $display("[TB] FAIL gs_single_pulse pc_en=%0b pc=%h required 0/00000004", pc_en, pcReg); end
    endtask

    task automatic test_wrap_reset();
        doReset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wr_addrF8 actual=%h required=fffffff8", imem_addr); end
        repeat (2) @(negedge clock);
        rvalidDelay = 5;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || pc_en !== 1'b1) begin errors++; $display("[TB] FAIL wr_acceptFC addr=%h pc_en=%0b required fffffffc/1", imem_addr, pc_en); end
        checks++; if (next_pc !== 32'h0) begin errors++; $display("[TB] FAIL wr_wrap actual=%h required=00000000", next_pc); end
        @(negedge clock); #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wr_head valid=%0b pc=%h required valid=1 pc=fffffff8", id_valid, id_pc); end
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        #1;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL wr_reset_now valid=%0b req=%0b required 0/0", id_valid, imem_req); end
        checks++; if (pc_en !== 1'b0 || next_pc !== 32'h0) begin errors++; $display("[TB] FAIL wr_reset_pc pc_en=%0b next_pc=%h required 0/00000000", pc_en, next_pc); end
        @(negedge clock);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_after_reset req=%0b addr=%h valid=%0b required 1/0/0", imem_req, imem_addr, id_valid); end
    endtask

    initial begin
        clock  = 1'b0;
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid_pop();
        test_gnt_stall();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage controller between the program counter register and the decode stage. It reads the current PC and drives next_pc/pc_en back into the PC register. It issues one instruction-memory request at a time over a req/gnt/rvalid handshake and buffers returned instructions in a small FIFO toward IF/ID. Branch/jump redirects from EX flush the buffer and squash any in-flight response.

Parameters:
DEPTH, 2, fetch buffer entries (power of two, >=2)
RESET_PC, 32'h0000_0000, address of the first fetch after reset; must match the PC register's reset value

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pc  input  32  current PC from the PC register
next_pc  output  32  next PC value to the PC register
pc_en  output  1  PC load enable to the PC register
imem_req  output  1  instruction memory request
imem_addr  output  32  request address, always equal to pc
imem_gnt  input  1  request accepted when high together with imem_req
imem_rvalid  input  1  read data valid; at least 1 cycle after gnt
imem_rdata  input  32  instruction word
redirect_valid  input  1  taken branch/jump from EX
redirect_pc  input  32  redirect target
id_valid  output  1  buffer head valid toward decode
id_ready  input  1  decode accepts head
id_instr  output  32  head instruction
id_pc  output  32  PC of head instruction

Behaviour:
- Clock and reset: one clock, clock. Reset is asynchronous and active-high. While reset is high:
  - state = FETCH, buffer empty, drop flag cleared, id_valid = 0.
  - imem_req = 0, pc_en = 0, next_pc = RESET_PC.
- States:
  - FETCH: no request outstanding.
  - WAIT: one request granted, response pending.
  - Registers: req_pc (address of the outstanding request) and drop.
- Credit rule:
  - imem_req = (state==FETCH) && (count < DEPTH) && !redirect_valid.
  - At most one request is outstanding, so a push never overflows the buffer.
- Request accept: imem_req && imem_gnt in the same cycle:
  - pc_en = 1, next_pc = pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - req_pc <= pc, state <= WAIT.
  - No gnt: hold imem_req and imem_addr stable, pc_en = 0.
- Response in WAIT on imem_rvalid:
  - If drop = 0, push {req_pc, imem_rdata}.
  - If drop = 1, discard the word and clear drop.
  - State <= FETCH. The next request can issue the cycle after, so throughput is at most 1 instruction per 2 cycles.
- imem_rvalid outside WAIT is ignored.
- Pop: id_valid = (count != 0). id_instr and id_pc come from the head entry. id_valid && id_ready pops at the clock edge. Push and pop in the same cycle keep count unchanged.
- Redirect, which has highest priority:
  - Combinational: pc_en = 1, next_pc = {redirect_pc[31:2], 2'b00}. Any accept that cycle is suppressed because imem_req is forced to 0.
  - The buffer is flushed at the edge; id_valid = 0 next cycle. A simultaneous pop is void.
  - In WAIT without rvalid: set drop, stay in WAIT.
  - In WAIT with rvalid the same cycle: the response is discarded, state <= FETCH, drop stays 0.
  - In FETCH: the next cycle's request uses the redirected pc.
- Back-to-back redirects: the last one wins. drop remains set, and only one response is discarded because at most one is in flight.
- Reset mid-WAIT: outstanding state is lost. The memory side is reset by the same reset, so no stale rvalid arrives.
- next_pc default when pc_en = 0: pc (don't-care to the PC register, driven for determinism).

Test Plan:
- Reset release, pc=0, gnt tied 1, rvalid 1 cycle after gnt, id_ready=1:
  - requests at 0, 4, 8 on every other cycle.
  - id_pc sequence 0, 4, 8 with matching imem_rdata.
  - pc_en pulses once per accept with next_pc = pc + 4.
- id_ready=0, DEPTH=2:
  - after 2 pushes imem_req stays 0 and pc_en 0 indefinitely.
  - raising id_ready pops 0 then 4 and fetching resumes at 8.
- Redirect to 32'h0000_0103 while WAIT for pc=0x10:
  - next_pc = 0x100, pc_en = 1.
  - the 0x10 response is discarded.
  - the next id_pc is 0x100, and the buffer was flushed.
- Redirect coinciding with rvalid and with a pop:
  - the rvalid word is not pushed, the pop is voided, id_valid = 0 next cycle, state returns to FETCH.
- gnt withheld 3 cycles:
  - imem_req and imem_addr stay stable, pc_en = 0.
  - on gnt, a single pc_en pulse.
- pc = 32'hFFFF_FFFC accept -> next_pc = 0. Assert reset in WAIT -> id_valid = 0, imem_req = 0, pc_en = 0 immediately.
